// File: rtl/alu_op_sequencer.sv
// Hardwired control sequencer for Datapath: instruction fetch (T0-T2) followed by
// register-to-register ALU execution (T3-T6), with Moore outputs decoded from state and IR.
module alu_op_sequencer (
   input  logic        clk,
   input  logic        clr,
   input  logic        run,
   input  logic        mem_rdy,
   input  logic [31:0] IR,
   output logic        PCout,
   output logic        MARin,
   output logic        Zin,
   output logic        PCin,
   output logic        Read,
   output logic        MDRin,
   output logic        MDRout,
   output logic        IRin,
   output logic        Yin,
   output logic        Zlowout,
   output logic        Zhighout,
   output logic        HIin,
   output logic        LOin,
   output logic [4:0]  OpCode,
   output logic [15:0] Rout,
   output logic [15:0] Rin,
   output logic        instr_done,
   output logic        halted,
   output logic        illegal
);

   localparam logic [4:0] IncOp  = 5'd12;
   localparam logic [4:0] NopOp  = 5'd26;
   localparam logic [4:0] HaltOp = 5'd27;

   typedef enum logic [3:0] {
      StIdle, StT0, StT1, StT2, StT3, StT4, StT5, StT6, StHalt
   } state_e;

   state_e state_q, state_d;
   logic   illegal_q, illegal_d;
   logic   t1_first_q;

   logic [4:0]  op;
   logic [15:0] ra_oh, rb_oh, rc_oh;
   logic        is_r, is_md, is_u;
   logic        unused_ir_bits;

   assign op    = IR[31:27];
   assign ra_oh = 16'd1 << IR[26:23];
   assign rb_oh = 16'd1 << IR[22:19];
   assign rc_oh = 16'd1 << IR[18:15];
   assign is_r  = (op <= 5'd11);
   assign is_md = (op == 5'd15) || (op == 5'd16);
   assign is_u  = (op == 5'd17) || (op == 5'd18);
   assign unused_ir_bits = ^IR[14:0];

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state_q    <= StIdle;
         illegal_q  <= 1'b0;
         t1_first_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         illegal_q  <= illegal_d;
         // Only the cycle right after T0 is the first T1 cycle; wait cycles see 0.
         t1_first_q <= (state_q == StT0);
      end
   end

   always_comb begin
      state_d    = state_q;
      illegal_d  = illegal_q;
      PCout      = 1'b0;
      MARin      = 1'b0;
      Zin        = 1'b0;
      PCin       = 1'b0;
      Read       = 1'b0;
      MDRin      = 1'b0;
      MDRout     = 1'b0;
      IRin       = 1'b0;
      Yin        = 1'b0;
      Zlowout    = 1'b0;
      Zhighout   = 1'b0;
      HIin       = 1'b0;
      LOin       = 1'b0;
      OpCode     = 5'd0;
      Rout       = 16'd0;
      Rin        = 16'd0;
      instr_done = 1'b0;

      case (state_q)
         StIdle: if (run) state_d = StT0;
         StT0: begin
            PCout   = 1'b1;
            MARin   = 1'b1;
            Zin     = 1'b1;
            OpCode  = IncOp;
            state_d = StT1;
         end
         StT1: begin
            Read    = 1'b1;
            MDRin   = 1'b1;
            PCin    = t1_first_q;
            Zlowout = t1_first_q;
            if (mem_rdy) state_d = StT2;
         end
         StT2: begin
            MDRout = 1'b1;
            IRin   = 1'b1;
            if (op == NopOp) begin
               instr_done = 1'b1;
               state_d    = run ? StT0 : StIdle;
            end else begin
               state_d = StT3;
            end
         end
         StT3: begin
            if (is_r) begin
               Rout    = rb_oh;
               Yin     = 1'b1;
               state_d = StT4;
            end else if (is_md) begin
               Rout    = ra_oh;
               Yin     = 1'b1;
               state_d = StT4;
            end else if (is_u) begin
               Rout    = rb_oh;
               OpCode  = op;
               Zin     = 1'b1;
               state_d = StT4;
            end else begin
               illegal_d = illegal_q | (op != HaltOp);
               state_d   = StHalt;
            end
         end
         StT4: begin
            if (is_u) begin
               Zlowout    = 1'b1;
               Rin        = ra_oh;
               instr_done = 1'b1;
               state_d    = run ? StT0 : StIdle;
            end else begin
               Rout    = is_md ? rb_oh : rc_oh;
               OpCode  = op;
               Zin     = 1'b1;
               state_d = StT5;
            end
         end
         StT5: begin
            Zlowout = 1'b1;
            if (is_md) begin
               LOin    = 1'b1;
               state_d = StT6;
            end else begin
               Rin        = ra_oh;
               instr_done = 1'b1;
               state_d    = run ? StT0 : StIdle;
            end
         end
         StT6: begin
            Zhighout   = 1'b1;
            HIin       = 1'b1;
            instr_done = 1'b1;
            state_d    = run ? StT0 : StIdle;
         end
         StHalt: state_d = StHalt;
         default: state_d = StIdle;
      endcase
   end

   assign halted  = (state_q == StHalt);
   assign illegal = illegal_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed-vector bench for alu_op_sequencer: checks every output cycle by cycle against
// hand-computed control words for R, MD, U, NOP, HALT and illegal instructions plus aborts.
module tb_alu_op_sequencer;

   localparam logic [12:0] CPcOut  = 13'h1000;
   localparam logic [12:0] CMarIn  = 13'h0800;
   localparam logic [12:0] CZIn    = 13'h0400;
   localparam logic [12:0] CPcIn   = 13'h0200;
   localparam logic [12:0] CRead   = 13'h0100;
   localparam logic [12:0] CMdrIn  = 13'h0080;
   localparam logic [12:0] CMdrOut = 13'h0040;
   localparam logic [12:0] CIrIn   = 13'h0020;
   localparam logic [12:0] CYIn    = 13'h0010;
   localparam logic [12:0] CZLo    = 13'h0008;
   localparam logic [12:0] CZHi    = 13'h0004;
   localparam logic [12:0] CHiIn   = 13'h0002;
   localparam logic [12:0] CLoIn   = 13'h0001;

   localparam logic [31:0] IrAnd  = 32'h2891_8000;
   localparam logic [31:0] IrMul  = 32'h7A28_0000;
   localparam logic [31:0] IrNeg  = 32'h8B38_0000;
   localparam logic [31:0] IrHalt = 32'hD800_0000;
   localparam logic [31:0] IrIll  = 32'hF800_0000;
   localparam logic [31:0] IrNop  = 32'hD000_0000;

   logic        clk, clr, run, mem_rdy;
   logic [31:0] IR;
   logic        PCout, MARin, Zin, PCin, Read, MDRin, MDRout, IRin, Yin;
   logic        Zlowout, Zhighout, HIin, LOin;
   logic [4:0]  OpCode;
   logic [15:0] Rout, Rin;
   logic        instr_done, halted, illegal;
   logic [12:0] ctrl;

   int n_checks = 0;
   int n_fail   = 0;

   alu_op_sequencer u_dut (
      .clk        (clk),
      .clr        (clr),
      .run        (run),
      .mem_rdy    (mem_rdy),
      .IR         (IR),
      .PCout      (PCout),
      .MARin      (MARin),
      .Zin        (Zin),
      .PCin       (PCin),
      .Read       (Read),
      .MDRin      (MDRin),
      .MDRout     (MDRout),
      .IRin       (IRin),
      .Yin        (Yin),
      .Zlowout    (Zlowout),
      .Zhighout   (Zhighout),
      .HIin       (HIin),
      .LOin       (LOin),
      .OpCode     (OpCode),
      .Rout       (Rout),
      .Rin        (Rin),
      .instr_done (instr_done),
      .halted     (halted),
      .illegal    (illegal)
   );

   assign ctrl = {PCout, MARin, Zin, PCin, Read, MDRin, MDRout, IRin, Yin,
                  Zlowout, Zhighout, HIin, LOin};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Compare the full output set of the current cycle.
   task automatic cyc(input string tag, input logic [12:0] c, input logic [4:0] op,
                      input logic [15:0] ro, input logic [15:0] ri, input logic dn,
                      input logic hl, input logic il);
      check({tag, ".ctrl"}, 32'(ctrl), 32'(c));
      check({tag, ".opcode"}, 32'(OpCode), 32'(op));
      check({tag, ".rout"}, 32'(Rout), 32'(ro));
      check({tag, ".rin"}, 32'(Rin), 32'(ri));
      check({tag, ".done"}, 32'(instr_done), 32'(dn));
      check({tag, ".halted"}, 32'(halted), 32'(hl));
      check({tag, ".illegal"}, 32'(illegal), 32'(il));
   endtask

   task automatic fetch(input string tag, input int waits, input logic nop);
      @(negedge clk);
      cyc({tag, ".t0"}, CPcOut | CMarIn | CZIn, 5'd12, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      cyc({tag, ".t1"}, CZLo | CPcIn | CRead | CMdrIn, 5'd0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
      mem_rdy = (waits == 0);
      for (int i = 0; i < waits; i++) begin
         @(negedge clk);
         cyc({tag, ".t1w"}, CRead | CMdrIn, 5'd0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
         mem_rdy = (i == waits - 1);
      end
      @(negedge clk);
      cyc({tag, ".t2"}, CMdrOut | CIrIn, 5'd0, 16'h0, 16'h0, nop, 1'b0, 1'b0);
   endtask

   task automatic idle(input string tag);
      @(negedge clk);
      cyc(tag, 13'h0, 5'd0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      clr = 1'b1; run = 1'b1; mem_rdy = 1'b1; IR = IrAnd;
      #1 clr = 1'b0;
      #1 cyc("reset", 13'h0, 5'd0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
      idle("reset_hold");
      clr = 1'b1;

      // and R1,R2,R3
      fetch("and", 0, 1'b0);
      @(negedge clk); cyc("and.t3", CYIn, 5'd0, 16'h0004, 16'h0, 1'b0, 1'b0, 1'b0);
      @(negedge clk); cyc("and.t4", CZIn, 5'd5, 16'h0008, 16'h0, 1'b0, 1'b0, 1'b0);
      @(negedge clk); cyc("and.t5", CZLo, 5'd0, 16'h0, 16'h0002, 1'b1, 1'b0, 1'b0);
      run = 1'b0;
      idle("and.idle");

      // mul R4,R5 with two memory wait cycles, then back-to-back neg
      IR = IrMul; run = 1'b1;
      fetch("mul", 2, 1'b0);
      @(negedge clk); cyc("mul.t3", CYIn, 5'd0, 16'h0010, 16'h0, 1'b0, 1'b0, 1'b0);
      @(negedge clk); cyc("mul.t4", CZIn, 5'd15, 16'h0020, 16'h0, 1'b0, 1'b0, 1'b0);
      @(negedge clk); cyc("mul.t5", CZLo | CLoIn, 5'd0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
      @(negedge clk); cyc("mul.t6", CZHi | CHiIn, 5'd0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0);
      IR = IrNeg;

      // neg R6,R7 with run dropped mid-instruction
      fetch("neg", 0, 1'b0);
      @(negedge clk); cyc("neg.t3", CZIn, 5'd17, 16'h0080, 16'h0, 1'b0, 1'b0, 1'b0);
      run = 1'b0;
      @(negedge clk); cyc("neg.t4", CZLo, 5'd0, 16'h0, 16'h0040, 1'b1, 1'b0, 1'b0);
      idle("neg.idle");

      // clr during T4 aborts immediately
      IR = IrAnd; run = 1'b1;
      fetch("abt", 0, 1'b0);
      @(negedge clk); cyc("abt.t3", CYIn, 5'd0, 16'h0004, 16'h0, 1'b0, 1'b0, 1'b0);
      @(negedge clk); cyc("abt.t4", CZIn, 5'd5, 16'h0008, 16'h0, 1'b0, 1'b0, 1'b0);
      #1 clr = 1'b0;
      #1 cyc("abt.clr", 13'h0, 5'd0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
      idle("abt.hold");
      clr = 1'b1;
      fetch("rst", 0, 1'b0);
      @(negedge clk); cyc("rst.t3", CYIn, 5'd0, 16'h0004, 16'h0, 1'b0, 1'b0, 1'b0);
      @(negedge clk); cyc("rst.t4", CZIn, 5'd5, 16'h0008, 16'h0, 1'b0, 1'b0, 1'b0);
      @(negedge clk); cyc("rst.t5", CZLo, 5'd0, 16'h0, 16'h0002, 1'b1, 1'b0, 1'b0);
      run = 1'b0;
      idle("rst.idle");

      // HALT_OP: halted, not illegal, stays put with run high
      IR = IrHalt; run = 1'b1;
      fetch("hlt", 0, 1'b0);
      @(negedge clk); cyc("hlt.t3", 13'h0, 5'd0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
      @(negedge clk); cyc("hlt.st", 13'h0, 5'd0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0);
      @(negedge clk); cyc("hlt.stay", 13'h0, 5'd0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0);
      clr = 1'b0;
      #1 cyc("hlt.clr", 13'h0, 5'd0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);

      // Unsupported opcode: sticky illegal, cleared by clr
      IR = IrIll;
      @(negedge clk); clr = 1'b1;
      fetch("ill", 0, 1'b0);
      @(negedge clk); cyc("ill.t3", 13'h0, 5'd0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
      @(negedge clk); cyc("ill.st", 13'h0, 5'd0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b1);
      @(negedge clk); cyc("ill.stay", 13'h0, 5'd0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b1);
      clr = 1'b0;
      #1 cyc("ill.clr", 13'h0, 5'd0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);

      // NOP completes in T2
      IR = IrNop;
      @(negedge clk); clr = 1'b1;
      fetch("nop", 0, 1'b1);
      run = 1'b0;
      idle("nop.idle");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
